// File: rtl/pulp_fetch_adapter.sv
// Fetch adapter between core instruction-fetch ports and an instruction cache.
// Each port has its own request FIFO, response path, flush FSM and stall counter.
module pulp_fetch_adapter #(
  parameter int unsigned NumFetchPorts  = 1,
  parameter int unsigned FetchAddrWidth = 32,
  parameter int unsigned FetchDataWidth = 32,
  parameter int unsigned ReqDepth       = 2,
  parameter int unsigned RspCut         = 0,
  parameter int unsigned StallCntWidth  = 16
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [NumFetchPorts-1:0]                      fetch_req_i,
  input  logic [NumFetchPorts-1:0][FetchAddrWidth-1:0]  fetch_addr_i,
  output logic [NumFetchPorts-1:0]                      fetch_gnt_o,
  output logic [NumFetchPorts-1:0]                      fetch_rvalid_o,
  output logic [NumFetchPorts-1:0][FetchDataWidth-1:0]  fetch_rdata_o,
  output logic [NumFetchPorts-1:0]                      fetch_rerror_o,
  input  logic [NumFetchPorts-1:0]                      flush_valid_i,
  output logic [NumFetchPorts-1:0]                      flush_ready_o,
  output logic [NumFetchPorts-1:0]                      cache_valid_o,
  output logic [NumFetchPorts-1:0][FetchAddrWidth-1:0]  cache_addr_o,
  input  logic [NumFetchPorts-1:0]                      cache_ready_i,
  input  logic [NumFetchPorts-1:0][FetchDataWidth-1:0]  cache_rdata_i,
  input  logic [NumFetchPorts-1:0]                      cache_rerror_i,
  output logic [NumFetchPorts-1:0]                      cache_flush_valid_o,
  input  logic [NumFetchPorts-1:0]                      cache_flush_ready_i,
  output logic [NumFetchPorts-1:0][StallCntWidth-1:0]   stall_cnt_o
);

  typedef enum logic [1:0] {
    FLUSH_IDLE,
    FLUSH_DRAIN,
    FLUSH_FWD
  } flush_state_e;

  for (genvar p = 0; p < NumFetchPorts; p++) begin : g_port
    flush_state_e              state_q, state_d;
    logic                      idle;
    logic                      gnt;
    logic                      cvalid;
    logic [FetchAddrWidth-1:0] caddr;
    logic                      accept;
    logic                      fifo_drained;
    logic                      drained;
    logic [FetchDataWidth-1:0] rdata_q;
    logic                      rerror_q;
    logic [StallCntWidth-1:0]  stall_q;

    // Gating with rst_ni keeps every request-side output low while reset is held.
    assign idle = rst_ni && (state_q == FLUSH_IDLE);

    if (ReqDepth > 0) begin : g_fifo
      localparam int unsigned PtrW = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
      localparam int unsigned CntW = $clog2(ReqDepth + 1);

      logic [FetchAddrWidth-1:0] mem_q [ReqDepth];
      logic [PtrW-1:0]           rd_ptr_q, wr_ptr_q;
      logic [CntW-1:0]           count_q;
      logic                      full;

      assign full   = (count_q == CntW'(ReqDepth));
      assign cvalid = (count_q != '0);
      assign caddr  = mem_q[rd_ptr_q];
      assign accept = cvalid & cache_ready_i[p];
      // A pop in the same cycle frees a slot, so a full FIFO can still grant.
      assign gnt    = fetch_req_i[p] & idle & (~full | accept);
      // No pushes happen while draining, so only the pop can empty the FIFO.
      assign fifo_drained = (count_q == '0) || ((count_q == CntW'(1)) && accept);

      // NOTE: the storage array has no reset; pointers and occupancy are reset,
      // so stale entries are never presented and the array maps onto plain flops/RAM.
      always_ff @(posedge clk_i) begin
        if (gnt) mem_q[wr_ptr_q] <= fetch_addr_i[p];
      end

      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rd_ptr_q <= '0;
          wr_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          if (gnt) wr_ptr_q <= (wr_ptr_q == PtrW'(ReqDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
          if (accept) rd_ptr_q <= (rd_ptr_q == PtrW'(ReqDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
          if (gnt && !accept)      count_q <= count_q + 1'b1;
          else if (!gnt && accept) count_q <= count_q - 1'b1;
        end
      end
    end else begin : g_bypass
      assign cvalid       = fetch_req_i[p] & idle;
      assign caddr        = fetch_addr_i[p];
      assign accept       = cvalid & cache_ready_i[p];
      assign gnt          = accept;
      assign fifo_drained = 1'b1;
    end

    // Last accepted response; serves as the cut register and as the hold value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rdata_q  <= '0;
        rerror_q <= 1'b0;
      end else if (accept) begin
        rdata_q  <= cache_rdata_i[p];
        rerror_q <= cache_rerror_i[p];
      end
    end

    if (RspCut != 0) begin : g_cut
      logic rvalid_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rvalid_q <= 1'b0;
        else         rvalid_q <= accept;
      end

      assign fetch_rvalid_o[p] = rvalid_q;
      assign fetch_rdata_o[p]  = rdata_q;
      assign fetch_rerror_o[p] = rerror_q;
      // An accept this cycle still owes a registered response next cycle.
      assign drained           = fifo_drained & ~accept;
    end else begin : g_pass
      assign fetch_rvalid_o[p] = accept;
      assign fetch_rdata_o[p]  = accept ? cache_rdata_i[p] : rdata_q;
      assign fetch_rerror_o[p] = accept ? cache_rerror_i[p] : rerror_q;
      assign drained           = fifo_drained;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= FLUSH_IDLE;
      else         state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
      state_d                = state_q;
      cache_flush_valid_o[p] = 1'b0;
      flush_ready_o[p]       = 1'b0;
      unique case (state_q)
        FLUSH_IDLE:  if (flush_valid_i[p]) state_d = FLUSH_DRAIN;
        FLUSH_DRAIN: if (drained)          state_d = FLUSH_FWD;
        FLUSH_FWD: begin
          cache_flush_valid_o[p] = 1'b1;
          flush_ready_o[p]       = cache_flush_ready_i[p];
          if (cache_flush_ready_i[p]) state_d = FLUSH_IDLE;
        end
        default: state_d = FLUSH_IDLE;
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stall_q <= '0;
      end else if (fetch_req_i[p] && !gnt && !(&stall_q)) begin
        stall_q <= stall_q + 1'b1;
      end
    end

    assign fetch_gnt_o[p]   = gnt;
    assign cache_valid_o[p] = cvalid;
    assign cache_addr_o[p]  = caddr;
    assign stall_cnt_o[p]   = stall_q;
  end

endmodule
